inst_queue: RTL and testbench



---
 rtl/inst_queue_pkg.sv | 19 +
 rtl/inst_queue_ram.sv | 33 +++
 rtl/inst_queue.sv | 124 ++++++++++++
 tb/tb_inst_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: bus widths, enable constants,
// reset pc values, default depth and the packed queue entry type.
package inst_queue_pkg;

  localparam int INST_BUS         = 32;
  localparam int PC_BUS           = 32;
  localparam logic ENABLE         = 1'b1;
  localparam logic DISABLE        = 1'b0;
  localparam logic [PC_BUS-1:0] PC_INITIAL  = 32'h0000_0000;
  localparam logic [PC_BUS-1:0] NPC_INITIAL = 32'h0000_0004;
  localparam int INST_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [INST_BUS-1:0] inst;
    logic [PC_BUS-1:0]   pc;
    logic [PC_BUS-1:0]   npc;
  } entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage: DEPTH x {inst, pc, npc} registers, two write ports and
// two asynchronous read ports.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  entry_t        wdata1,
  input  logic          we2,
  input  logic [AW-1:0] waddr2,
  input  entry_t        wdata2,
  input  logic [AW-1:0] raddr1,
  output entry_t        rdata1,
  input  logic [AW-1:0] raddr2,
  output entry_t        rdata2
);

  entry_t mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by count, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue circular instruction queue between fetch and the decoders.
// Optional INST_QUEUE_BYPASS_EN: zero-latency fetch-to-decode path when empty.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stop,
  input  logic                branch_flag,
  input  logic [1:0]          issue,
  input  logic [INST_BUS-1:0] in1_inst,
  input  logic [PC_BUS-1:0]   in1_pc,
  input  logic [PC_BUS-1:0]   in1_npc,
  input  logic [INST_BUS-1:0] in2_inst,
  input  logic [PC_BUS-1:0]   in2_pc,
  input  logic [PC_BUS-1:0]   in2_npc,
  output logic [INST_BUS-1:0] out1_inst,
  output logic [PC_BUS-1:0]   out1_pc,
  output logic [PC_BUS-1:0]   out1_npc,
  output logic                sendout_flag1,
  input  logic                launch_flag1,
  output logic [INST_BUS-1:0] out2_inst,
  output logic [PC_BUS-1:0]   out2_pc,
  output logic [PC_BUS-1:0]   out2_npc,
  output logic                sendout_flag2,
  input  logic                launch_flag2,
  output logic                instbuf_full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    head, tail;
  logic [CNT_W-1:0] count;
  entry_t           in1, in2, rd1, rd2, slot1, slot2, wdata1, wdata2;
  logic             active, bypass, vld1, vld2, pop1, pop2, we1, we2;
  logic [1:0]       n_push, n_pop;

  assign in1          = {in1_inst, in1_pc, in1_npc};
  assign in2          = {in2_inst, in2_pc, in2_npc};
  assign active       = !stop && !branch_flag;
  assign instbuf_full = count > CNT_W'(DEPTH - 2);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bypass = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass = active && (count == '0);
`endif
    if (bypass) begin
      // issue=10 promotes slot 2 to the oldest position.
      slot1 = issue[0] ? in1 : in2;
      vld1  = |issue;
      slot2 = in2;
      vld2  = &issue;
    end else begin
      slot1 = rd1;
      vld1  = count != '0;
      slot2 = rd2;
      vld2  = count > CNT_W'(1);
    end

    pop1 = active && launch_flag1 && vld1;
    pop2 = pop1 && launch_flag2 && vld2;

    we1    = 1'b0;
    we2    = 1'b0;
    wdata1 = slot1;
    wdata2 = slot2;
    if (bypass) begin
      // Only the unlaunched tail of the bypassed pair is stored, in order.
      if (!pop1) begin
        we1 = vld1;
        we2 = vld2;
      end else if (!pop2 && vld2) begin
        we1    = 1'b1;
        wdata1 = slot2;
      end
    end else if (active && !instbuf_full) begin
      we1    = |issue;
      wdata1 = issue[0] ? in1 : in2;
      we2    = &issue;
      wdata2 = in2;
    end

    n_push = {1'b0, we1} + {1'b0, we2};
    n_pop  = bypass ? 2'd0 : ({1'b0, pop1} + {1'b0, pop2});
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || branch_flag) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (!stop) begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  inst_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we1    (we1),
    .waddr1 (tail),
    .wdata1 (wdata1),
    .we2    (we2),
    .waddr2 (tail + AW'(1)),
    .wdata2 (wdata2),
    .raddr1 (head),
    .rdata1 (rd1),
    .raddr2 (head + AW'(1)),
    .rdata2 (rd2)
  );

  assign sendout_flag1 = vld1;
  assign sendout_flag2 = vld2;
  assign {out1_inst, out1_pc, out1_npc} = vld1 ? slot1 : '0;
  assign {out2_inst, out2_pc, out2_npc} = vld2 ? slot2 : '0;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, stop, branch_flag, launch_flag1, launch_flag2;
  logic [1:0]  issue;
  logic [31:0] in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;
  logic [31:0] out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc;
  logic        sendout_flag1, sendout_flag2, instbuf_full;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stop(stop), .branch_flag(branch_flag), .issue(issue),
    .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc),
    .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc),
    .out1_inst(out1_inst), .out1_pc(out1_pc), .out1_npc(out1_npc),
    .sendout_flag1(sendout_flag1), .launch_flag1(launch_flag1),
    .out2_inst(out2_inst), .out2_pc(out2_pc), .out2_npc(out2_npc),
    .sendout_flag2(sendout_flag2), .launch_flag2(launch_flag2),
    .instbuf_full(instbuf_full)
  );

  always #5 clk = ~clk;

  entry_t      mq[$];
  entry_t      inc[$];
  entry_t      vis[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] next_pc    = 32'h0;
  logic [31:0] saved_pc;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entries fetch offers this cycle, oldest first.
  task automatic build_inc();
    inc.delete();
    if (issue[0]) inc.push_back({in1_inst, in1_pc, in1_npc});
    if (issue[1]) inc.push_back({in2_inst, in2_pc, in2_npc});
  endtask

  task automatic build_vis();
    build_inc();
    vis = mq;
`ifdef INST_QUEUE_BYPASS_EN
    if (mq.size() == 0 && !stop && !branch_flag) vis = inc;
`endif
  endtask

  task automatic compare_outputs();
    entry_t e1, e2;
    build_vis();
    e1 = '0;
    e2 = '0;
    if (vis.size() >= 1) e1 = vis[0];
    if (vis.size() >= 2) e2 = vis[1];
    check("sendout_flag1", 96'(sendout_flag1), 96'(vis.size() >= 1));
    check("sendout_flag2", 96'(sendout_flag2), 96'(vis.size() >= 2));
    check("instbuf_full",  96'(instbuf_full),  96'(mq.size() > DEPTH - 2));
    check("out1", {out1_inst, out1_pc, out1_npc}, e1);
    check("out2", {out2_inst, out2_pc, out2_npc}, e2);
  endtask

  task automatic model_update();
    int n;
    bit full_before, bypass_now;
    build_inc();
    full_before = mq.size() > DEPTH - 2;
    if (rst || branch_flag) begin
      mq.delete();
    end else if (!stop) begin
      bypass_now = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      bypass_now = (mq.size() == 0);
`endif
      if (bypass_now) begin
        n = 0;
        if (launch_flag1 && inc.size() >= 1) n = 1;
        if (n == 1 && launch_flag2 && inc.size() >= 2) n = 2;
        for (int i = n; i < inc.size(); i++) mq.push_back(inc[i]);
      end else begin
        n = 0;
        if (launch_flag1 && mq.size() >= 1) n = 1;
        if (n == 1 && launch_flag2 && mq.size() >= 2) n = 2;
        repeat (n) void'(mq.pop_front());
        if (!full_before) foreach (inc[i]) mq.push_back(inc[i]);
      end
    end
  endtask

  task automatic set_data();
    in1_inst = $urandom;
    in1_pc   = next_pc;
    in1_npc  = next_pc + 32'd4;
    in2_inst = $urandom;
    in2_pc   = next_pc + 32'd4;
    in2_npc  = next_pc + 32'd8;
  endtask

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [1:0] iss,
                       input logic l1, input logic l2, input bit keep);
    rst = r; stop = s; branch_flag = b; issue = iss;
    launch_flag1 = l1; launch_flag2 = l2;
    if (!keep) set_data();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    if (iss != 2'b00) next_pc += 32'd8;
    #1;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; branch_flag = 1'b0; issue = 2'b00;
    launch_flag1 = 1'b0; launch_flag2 = 1'b0;
    set_data();
    repeat (2) @(posedge clk);
    model_update();
    #1;
    check("reset_flag1", 96'(sendout_flag1), 96'(0));
    check("reset_full",  96'(instbuf_full),  96'(0));
    check("reset_out1",  {out1_inst, out1_pc, out1_npc}, 96'(0));

    // Two-entry push, visible on the next cycle.
    in1_inst = 32'h0050_0093; in1_pc = 32'h0; in1_npc = 32'h4;
    in2_inst = 32'h00A0_0113; in2_pc = 32'h4; in2_npc = 32'h8;
    cycle(0, 0, 0, 2'b11, 0, 0, 1);
    check("t1_flag1",     96'(sendout_flag1), 96'(1));
    check("t1_flag2",     96'(sendout_flag2), 96'(1));
    check("t1_out1_pc",   96'(out1_pc),   96'(32'h0));
    check("t1_out2_pc",   96'(out2_pc),   96'(32'h4));
    check("t1_out1_inst", 96'(out1_inst), 96'(32'h0050_0093));

    // Fill to full; pcs 8..28 land, the push at pc 32/36 is discarded.
    cycle(0, 0, 0, 2'b11, 0, 0, 0);
    cycle(0, 0, 0, 2'b11, 0, 0, 0);
    check("t2_not_full_at_6", 96'(instbuf_full), 96'(0));
    cycle(0, 0, 0, 2'b11, 0, 0, 0);
    check("t2_full_at_8", 96'(instbuf_full), 96'(1));
    cycle(0, 0, 0, 2'b11, 0, 0, 0);
    check("t2_still_full", 96'(instbuf_full), 96'(1));

    // In-order retire: launch2 alone is ignored.
    cycle(0, 0, 0, 2'b00, 1, 1, 0);
    cycle(0, 0, 0, 2'b00, 1, 1, 0);
    check("t3_out1_pc_16", 96'(out1_pc), 96'(32'd16));
    cycle(0, 0, 0, 2'b00, 0, 1, 0);
    check("t3_no_retire", 96'(out1_pc), 96'(32'd16));
    cycle(0, 0, 0, 2'b00, 1, 1, 0);
    check("t3_third_entry", 96'(out1_pc), 96'(32'd24));

    // head=6, count=4 after this push; then pop 2 + push 2 across the wrap.
    cycle(0, 0, 0, 2'b11, 0, 0, 0);
    cycle(0, 0, 0, 2'b11, 1, 1, 0);
    check("t4_out1_wrap", 96'(out1_pc), 96'(32'd40));
    check("t4_out2_wrap", 96'(out2_pc), 96'(32'd44));
    check("t4_full_low",  96'(instbuf_full), 96'(0));

    // Flush wins over a simultaneous push.
    cycle(0, 0, 1, 2'b11, 1, 1, 0);
    check("t5_flag1", 96'(sendout_flag1), 96'(0));
    check("t5_out1",  {out1_inst, out1_pc, out1_npc}, 96'(0));
    saved_pc = next_pc;
    cycle(0, 0, 0, 2'b01, 0, 0, 0);
    check("t5_alone_flag2", 96'(sendout_flag2), 96'(0));
    check("t5_alone_pc",    96'(out1_pc), 96'(saved_pc));

    // Stop freezes everything.
    cycle(0, 0, 0, 2'b11, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 2'b11, 1, 0, 0);
    check("t6_stop_pc", 96'(out1_pc), 96'(saved_pc));

`ifdef INST_QUEUE_BYPASS_EN
    cycle(0, 0, 1, 2'b00, 0, 0, 0);
    branch_flag = 1'b0; stop = 1'b0; issue = 2'b11;
    launch_flag1 = 1'b1; launch_flag2 = 1'b0;
    set_data();
    saved_pc = next_pc;
    #1;
    check("byp_flag1_same_cycle", 96'(sendout_flag1), 96'(1));
    check("byp_out1_pc",          96'(out1_pc), 96'(saved_pc));
    cycle(0, 0, 0, 2'b11, 1, 0, 1);
    issue = 2'b00;
    #1;
    check("byp_count1_flag2", 96'(sendout_flag2), 96'(0));
    check("byp_stored_slot2", 96'(out1_pc), 96'(saved_pc + 32'd4));
`endif

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
